alu_seq_core: RTL
=================

// Module: alu_seq_core
// PURPOSE
//  Parametrised, registered successor to the 8-bit combinational ALU. Accepts one operation per
//  valid/ready handshake, returns a registered result plus ZNCV flags. Adds signed ops and
//  an optional iterative multiply. Sits between decode and writeback in the RISC datapath.
// PARAMETERS
//  WIDTH    8  operand/result width in bits (>=4)
//  OP_W     4  opcode width (fixed 4; values below)
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      core can accept (high only in IDLE)
//  op         in   OP_W   opcode, sampled on in_valid&&in_ready
//  a          in   WIDTH  source 1
//  b          in   WIDTH  source 2
//  out_valid  out  1      result/flags valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  flags      out  4      {Z,N,C,V}
//  illegal    out  1      opcode unsupported in this build; qualifies out_valid
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, flags=0, illegal=0.
//  FSM: IDLE -accept, op!=MUL-> DONE; IDLE -accept MUL-> BUSY; BUSY -WIDTH iterations-> DONE;
//   DONE -out_ready-> IDLE. Latency: 1 cycle accept->out_valid; MUL WIDTH+1 cycles.
//  No new accept while BUSY/DONE (in_ready=0); single outstanding op, no bypass of DONE.
//  Opcodes: 0 ADD, 1 SUB(a-b), 2 NOT a, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 XOR (as 8-bit ALU),
//   8 SRA, 9 SLT (signed, result 0/1), 10 SLTU, 11 PASSB, 12 MUL (low WIDTH bits), 13-15 illegal.
//  Shifts: amount = full unsigned b; amount>=WIDTH -> SLL/SRL give 0, SRA gives a[WIDTH-1] fill.
//  Flags: Z=(result==0); N=result[WIDTH-1]; C=carry-out for ADD, borrow (a<b unsigned) for SUB,
//   last bit shifted out for SLL/SRL/SRA (0 if amount==0 or >=WIDTH except SRA>=WIDTH: a msb),
//   0 otherwise; V=signed overflow for ADD/SUB, 0 otherwise.
//  Illegal op: result=0, flags=0, illegal=1, normal 1-cycle DONE handshake.
//  Output regs stable while out_valid&&!out_ready. Reset mid-BUSY/DONE aborts op, drops result.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: op 12 runs shift-add multiply, WIDTH cycles in BUSY; Z,N from result,
//   C=1 iff high product half nonzero, V=0.
//  Not defined: BUSY state and multiplier absent; op 12 treated as illegal (1-cycle).
// STRUCTURE
//  alu_seq_pkg: opcode localparams/enum (OP_ADD..OP_MUL), flag bit indices (FLG_Z=3..FLG_V=0),
//   FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE).
//  Sub-module alu_seq_mul (under ALU_SEQ_MUL_EN): start/done iterative shift-add multiplier,
//   counter $clog2(WIDTH)+1 bits, returns 2*WIDTH product.
//  Top: FSM, combinational op mux, flag generation, output registers.
// TESTING (WIDTH=8)
//  ADD a=0xFF b=0x01 -> result 0x00, out_valid next cycle, flags Z=1 N=0 C=1 V=0.
//  SUB a=0x80 b=0x01 -> 0x7F, Z=0 N=0 C=0 V=1; SLT a=0x80 b=0x01 -> 0x01, SLTU -> 0x00.
//  SRA a=0x90 b=9 -> 0xFF, C=1; SLL a=0x81 b=1 -> 0x02, C=1; SRL a=0x01 b=8 -> 0x00, Z=1.
//  Backpressure: out_ready=0 for 5 cycles after result -> result/flags stable, in_ready=0,
//   second in_valid not accepted until handshake completes.
//  MUL 0x12*0x10: with ALU_SEQ_MUL_EN -> out_valid at cycle 9, result 0x20, C=1;
//   without -> illegal=1 at cycle 1, result 0x00.
//  Op 14 -> illegal=1, result 0; rst_n pulsed low mid-MUL -> out_valid=0, in_ready=1 immediately.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// Module  : alu_seq_pkg
// Brief   : Opcodes, flag bit positions and FSM encoding for alu_seq_core.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_NOT   = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_SRL   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;
  localparam logic [3:0] OP_MUL   = 4'd12;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_seq_mul.sv
// ============================================================================
// Module  : alu_seq_mul
// Brief   : Iterative shift-add multiplier, one partial product per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic                 busy_q,   busy_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   w_acc_next;

  // Done and product are presented during the final iteration so the
  // caller can capture the full product on the same edge.
  assign w_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o     = busy_q && (cnt_q == LAST);
  assign product_o  = w_acc_next;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
    end else if (busy_q) begin
      acc_d    = w_acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done_o) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_core.sv
// ============================================================================
// Module  : alu_seq_core
// Brief   : Registered valid/ready ALU with ZNCV flags; ALU_SEQ_MUL_EN adds MUL.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] W_LIM = WIDTH[WIDTH-1:0];

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic [3:0]       flags_q,   flags_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH:0]   w_add, w_sub, w_sll_x, w_srl_x, w_sra_x;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_ill, w_big, w_slt, w_sltu, w_op_mul;
  logic [3:0]       w_alu_flags;

  // Shifts run on a one-bit-extended operand so the last bit shifted out
  // lands in the extension bit.
  assign w_add   = {1'b0, a} + {1'b0, b};
  assign w_sub   = {1'b0, a} - {1'b0, b};
  assign w_sll_x = {1'b0, a} << b;
  assign w_srl_x = {a, 1'b0} >> b;
  assign w_sra_x = $unsigned($signed({a, 1'b0}) >>> b);
  assign w_big   = (b >= W_LIM);
  assign w_slt   = ($signed(a) < $signed(b));
  assign w_sltu  = (a < b);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_ill = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:   w_res = ~a;
      OP_SLL: begin
        w_res = w_sll_x[WIDTH-1:0];
        w_c   = w_sll_x[WIDTH] && !w_big;
      end
      OP_SRL: begin
        w_res = w_srl_x[WIDTH:1];
        w_c   = w_srl_x[0] && !w_big;
      end
      OP_AND:   w_res = a & b;
      OP_OR:    w_res = a | b;
      OP_XOR:   w_res = a ^ b;
      OP_SRA: begin
        w_res = w_sra_x[WIDTH:1];
        w_c   = w_sra_x[0];
      end
      OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, w_sltu};
      OP_PASSB: w_res = b;
      default:  w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_alu_flags = 4'b0000;
    if (!w_ill) begin
      w_alu_flags[FLG_Z] = (w_res == '0);
      w_alu_flags[FLG_N] = w_res[WIDTH-1];
      w_alu_flags[FLG_C] = w_c;
      w_alu_flags[FLG_V] = w_v;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign w_op_mul    = (op == OP_MUL);
  assign w_mul_start = (state_q == ST_IDLE) && in_valid && w_op_mul;

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (w_mul_start),
    .a_i       (a),
    .b_i       (b),
    .done_o    (w_mul_done),
    .product_o (w_prod)
  );
`else
  assign w_op_mul = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (w_op_mul) begin
            state_d = ST_BUSY;
          end else begin
            result_d  = w_res;
            flags_d   = w_alu_flags;
            illegal_d = w_ill;
            state_d   = ST_DONE;
          end
        end
      end
`ifdef ALU_SEQ_MUL_EN
      ST_BUSY: begin
        if (w_mul_done) begin
          result_d         = w_prod[WIDTH-1:0];
          flags_d          = 4'b0000;
          flags_d[FLG_Z]   = (w_prod[WIDTH-1:0] == '0);
          flags_d[FLG_N]   = w_prod[WIDTH-1];
          flags_d[FLG_C]   = |w_prod[2*WIDTH-1:WIDTH];
          illegal_d        = 1'b0;
          state_d          = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      flags_q   <= 4'b0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign illegal   = illegal_q;

endmodule

`default_nettype wire
